bus_dma_host: RTL
=================

Name: bus_dma_host

Overview:
- Word-granular copy/fill engine that acts as an initiator (host) on the SoC pipelined bus.
- Drives the same host-side signal set that a CPU core presents to the bus hub, so it slots in as a second bus master or as the sole master in test SoCs.
- Commanded through a simple start/parameter port. Reports busy, a done pulse, and a timeout error.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles to wait for host_ready on a single beat before aborting with error.
- LEN_W, 16: width of the transfer length (words).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command strobe; ignored while busy
- mode  in  1  0 = copy (read src, write dst), 1 = fill (write fill_value to dst)
- src_addr  in  32  source byte address (bits [1:0] ignored)
- dst_addr  in  32  destination byte address (bits [1:0] ignored)
- len_words  in  LEN_W  number of 32-bit words to transfer
- fill_value  in  32  data written in fill mode
- abort  in  1  stop at the next beat boundary
- busy  out  1  high from the cycle after an accepted start until done/error
- done  out  1  one-cycle pulse on normal or aborted completion
- error  out  1  sticky timeout flag; cleared by the next accepted start
- words_done  out  LEN_W  count of completed write beats
- host_address  out  32  bus address, word aligned
- host_data_write  out  32  write data
- host_write_mask  out  4  always 4'b1111 on writes, 4'b0000 otherwise
- host_wen  out  1  write request
- host_ren  out  1  read request
- host_data_read  in  32  read data, valid when host_ready=1
- host_ready  in  1  transaction complete strobe

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - All outputs 0: busy, done, error, words_done, host_*.
  - A reset mid-transfer drops the request immediately. No completion pulse is issued.
- Bus handshake rules:
  - Exactly one of host_ren/host_wen is asserted per beat.
  - host_address, host_data_write and host_write_mask stay stable while the request is high.
  - The request is held until host_ready is sampled 1. It is deasserted the following cycle; that cycle is always idle, with no back-to-back requests.
  - host_data_read is captured into an internal 32-bit data register in the ready cycle.
- Command acceptance:
  - Accepted when start=1 in IDLE. Addresses, mode, len and fill are latched with bits [1:0] forced to 0.
  - error and words_done are cleared.
  - start while busy is ignored.
- FSM states: IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, FINISH.
  - IDLE -> FINISH if len_words==0; else RD_REQ (copy) or WR_REQ (fill).
  - RD_REQ: host_ren=1 at src pointer. On host_ready -> RD_GAP.
  - RD_GAP (1 cycle) -> WR_REQ.
  - WR_REQ: host_wen=1 at dst pointer. Data = captured read data (copy) or fill_value. On host_ready -> WR_GAP, words_done+1, src+=4, dst+=4.
  - WR_GAP: -> FINISH if remaining==0 or abort was seen; else RD_REQ or WR_REQ per mode.
  - FINISH: done=1 for one cycle, busy=0 next, -> IDLE.
- Abort: sampled in any non-IDLE state and latched. The in-flight beat always completes its handshake; the transfer stops at the WR_GAP boundary. An abort during a read beat still completes that word's write.
- Timeout: a per-beat counter resets on entry to each REQ state. If it reaches TIMEOUT_CYCLES without ready, the request is dropped, error=1, and the state goes -> FINISH (done still pulses).
- Pointers wrap modulo 2^32 with no error.
- Latency per word: copy = 2 beats + 2 gap cycles; fill = 1 beat + 1 gap cycle, with a zero-wait responder (ready 1 cycle after request).

Decomposition:
- Shared bus package holds:
  - Bus width constants: ADDR_W=32, DATA_W=32, MASK_W=4.
  - A dma_state_t enum.
  - A typedef struct bundling the host-side outputs, reusable by other masters.
- One sub-module is natural: bus_beat_timer, the per-beat timeout counter with clear/enable/expired.

Test Plan:
- Copy, len=4, src=0x100, dst=0x200, 1-cycle-latency memory model preloaded 0xA0..0xA3 -> dst words equal 0xA0..0xA3, words_done=4, single done pulse, error=0, and an idle cycle between every request.
- Fill, len=3, dst=0x40, fill=0xDEADBEEF -> three writes to 0x40/0x44/0x48 with mask 4'hF, no host_ren ever asserted.
- len=0 start -> no bus activity, done pulses exactly 2 cycles after start, words_done=0.
- Responder never asserts ready, TIMEOUT_CYCLES=8 -> host_ren drops after 8 cycles, error=1, done pulses; the next start clears error.
- Abort asserted mid read of word 2 of 5 (copy) -> word 2 still written, words_done=3, done pulse, no further requests.
- rst_n pulled low during WR_REQ with 3-cycle responder latency -> host_wen=0 and busy=0 asynchronously, no done pulse; a new start after release runs normally. Misaligned src=0x103 is also checked to issue address 0x100.

Source files
------------

// File: rtl/bus_dma_host_pkg.sv
// Shared bus definitions for host-side (initiator) masters on the SoC
// pipelined bus: width constants, the DMA sequencer state type, and a
// struct bundling every host-side output so other masters can reuse it.
package bus_dma_host_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_GAP,
        WR_REQ,
        WR_GAP,
        FINISH
    } dma_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data_write;
        logic [MASK_W-1:0] write_mask;
        logic              wen;
        logic              ren;
    } host_req_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

    function automatic host_req_t read_beat(input logic [ADDR_W-1:0] addr);
        host_req_t r;
        r         = '0;
        r.address = addr;
        r.ren     = 1'b1;
        return r;
    endfunction

    function automatic host_req_t write_beat(input logic [ADDR_W-1:0] addr,
                                             input logic [DATA_W-1:0] data);
        host_req_t r;
        r            = '0;
        r.address    = addr;
        r.data_write = data;
        r.write_mask = '1;
        r.wen        = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/bus_dma_host_beat_timer.sv
// bus_beat_timer: per-beat wait counter for a bus request.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the count (held while no request is outstanding)
//   enable     : a request is outstanding this cycle
//   expired    : this is the last cycle the request may wait; if ready does
//                not arrive now, the request has been up TIMEOUT_CYCLES cycles
module bus_beat_timer
    import bus_dma_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // count == k during the (k+1)-th cycle of the request
    assign expired = enable && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bus_dma_host.sv
// bus_dma_host: word-granular copy/fill engine acting as a bus initiator.
//   start/mode/src_addr/dst_addr/len_words/fill_value : command, latched on
//       an accepted start (IDLE only); address bits [1:0] are dropped
//   abort      : finish at the next write-beat boundary
//   busy/done/error/words_done : status; error is sticky until next start
//   host_*     : host-side bus request, held until host_ready, then one
//                idle cycle before the next request
module bus_dma_host
    import bus_dma_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int LEN_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len_words,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  words_done,
    output logic [ADDR_W-1:0] host_address,
    output logic [DATA_W-1:0] host_data_write,
    output logic [MASK_W-1:0] host_write_mask,
    output logic              host_wen,
    output logic              host_ren,
    input  logic [DATA_W-1:0] host_data_read,
    input  logic              host_ready
);

    dma_state_t        state;
    host_req_t         host;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [DATA_W-1:0] fill_q;
    logic [DATA_W-1:0] rdata_q;
    logic [LEN_W-1:0]  remaining;
    logic              fill_mode;
    logic              abort_seen;
    logic              req_active;
    logic              beat_expired;

    assign host_address    = host.address;
    assign host_data_write = host.data_write;
    assign host_write_mask = host.write_mask;
    assign host_wen        = host.wen;
    assign host_ren        = host.ren;

    // Requests are only ever raised from an idle/gap cycle, so holding the
    // timer clear whenever no request is up restarts it on every beat.
    assign req_active = host.ren | host.wen;

    bus_beat_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!req_active),
        .enable (req_active),
        .expired(beat_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            host       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            words_done <= '0;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            fill_q     <= '0;
            rdata_q    <= '0;
            remaining  <= '0;
            fill_mode  <= 1'b0;
            abort_seen <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) abort_seen <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        error      <= 1'b0;
                        words_done <= '0;
                        abort_seen <= 1'b0;
                        src_ptr    <= word_align(src_addr);
                        dst_ptr    <= word_align(dst_addr);
                        fill_q     <= fill_value;
                        fill_mode  <= mode;
                        remaining  <= len_words;
                        if (len_words == '0) begin
                            state <= FINISH;
                        end else if (mode) begin
                            host  <= write_beat(word_align(dst_addr), fill_value);
                            state <= WR_REQ;
                        end else begin
                            host  <= read_beat(word_align(src_addr));
                            state <= RD_REQ;
                        end
                    end
                end

                RD_REQ: begin
                    if (host_ready) begin
                        rdata_q <= host_data_read;
                        host    <= '0;
                        state   <= RD_GAP;
                    end else if (beat_expired) begin
                        host  <= '0;
                        error <= 1'b1;
                        state <= FINISH;
                    end
                end

                RD_GAP: begin
                    host  <= write_beat(dst_ptr, rdata_q);
                    state <= WR_REQ;
                end

                WR_REQ: begin
                    if (host_ready) begin
                        host       <= '0;
                        words_done <= words_done + LEN_W'(1);
                        remaining  <= remaining - LEN_W'(1);
                        src_ptr    <= src_ptr + ADDR_W'(4);
                        dst_ptr    <= dst_ptr + ADDR_W'(4);
                        state      <= WR_GAP;
                    end else if (beat_expired) begin
                        host  <= '0;
                        error <= 1'b1;
                        state <= FINISH;
                    end
                end

                WR_GAP: begin
                    // abort arriving in this very cycle also stops here
                    if (remaining == '0 || abort_seen || abort) begin
                        state <= FINISH;
                    end else if (fill_mode) begin
                        host  <= write_beat(dst_ptr, fill_q);
                        state <= WR_REQ;
                    end else begin
                        host  <= read_beat(src_ptr);
                        state <= RD_REQ;
                    end
                end

                FINISH: begin
                    // busy falls in the same cycle done is shown, so a start
                    // seen alongside done is never dropped as "while busy"
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
